// File: rtl/inst_loader.sv
// Framed byte-stream loader writing instruction memory one byte per payload byte.
// Define INST_LOADER_CHECKSUM_EN to expect and verify a trailing checksum byte.
module inst_loader #(
    parameter int         instMem_addr_width = 13,
    parameter logic [7:0] SYNC_BYTE          = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          wr_en,
    output logic [instMem_addr_width-1:0] wr_addr,
    output logic [7:0]                    wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int AW = instMem_addr_width;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H,
        S_LEN_L, S_DATA, S_CHK, S_FINISH
    } state_e;

`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_e END_S = S_CHK;
`else
    localparam state_e END_S = S_FINISH;
`endif

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     len_q, len_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            busy_q, busy_d;
    logic            acc;
    logic [15:0]     len_full;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
    logic            err_q, err_d;
`endif

    assign in_ready = (state_q != S_FINISH) && !rst;
    assign acc      = in_valid && in_ready;
    assign len_full = {len_q[15:8], in_data};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        err_d     = err_q;
        // every header and payload byte enters the running sum
        if (acc && (state_q inside {S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA}))
            sum_d = sum_q + in_data;
`endif
        case (state_q)
            S_IDLE: begin
                if (acc && in_data == SYNC_BYTE) begin
                    state_d = S_ADDR_H;
                    busy_d  = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_ADDR_H: begin
                if (acc) begin
                    addr_d  = AW'({in_data, 8'h00});
                    state_d = S_ADDR_L;
                end
            end
            S_ADDR_L: begin
                if (acc) begin
                    addr_d  = addr_q | AW'(in_data);
                    state_d = S_LEN_H;
                end
            end
            S_LEN_H: begin
                if (acc) begin
                    len_d   = {in_data, 8'h00};
                    state_d = S_LEN_L;
                end
            end
            S_LEN_L: begin
                if (acc) begin
                    len_d   = len_full;
                    state_d = (len_full == 16'd0) ? END_S : S_DATA;
                end
            end
            S_DATA: begin
                if (acc) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = in_data;
                    addr_d    = addr_q + AW'(1);
                    len_d     = len_q - 16'd1;
                    if (len_q == 16'd1)
                        state_d = END_S;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (acc) begin
                    if (in_data == sum_q) begin
                        state_d = S_FINISH;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            err_q     <= err_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = (state_q == S_FINISH);
`ifdef INST_LOADER_CHECKSUM_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: doc/inst_loader.md
# inst_loader

Byte-stream program loader that fills the byte-wide instruction memory before or between CPU runs. Receives a framed byte stream over a valid/ready handshake, parses a header (start address, length), and issues one byte write per payload byte into instruction memory, low address = high byte, so 32-bit instructions are streamed MSB first. It holds the core via `busy` while a frame is in progress and reports completion or checksum failure.

## Interface
- `instMem_addr_width`, default 13: width of the write address; addresses wrap modulo 2^width.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_data` holds a valid byte.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader can accept a byte this cycle.
- `wr_en` output 1: instruction memory byte write strobe.
- `wr_addr` output instMem_addr_width: byte address of the write.
- `wr_data` output 8: byte to write.
- `busy` output 1: frame in progress; CPU must be held.
- `done` output 1: one-cycle pulse on successful frame end.
- `err` output 1: checksum mismatch flag, sticky.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`; no other byte has any effect.
- Frame format: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN payload bytes, CHK (CHK only with CHECKSUM_EN).
- States: IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, CHK, FINISH.
- IDLE: bytes other than SYNC_BYTE are accepted and discarded. SYNC_BYTE: go to ADDR_H, set `busy`, clear `err`, clear running sum.
- ADDR_H/ADDR_L: form a 16-bit address. Only the low instMem_addr_width bits are used. All 16 bits enter the checksum.
- LEN_H/LEN_L: form a 16-bit byte count. Length 0 goes straight to CHK, or to FINISH without CHECKSUM_EN.
- DATA: each accepted byte is written at the current address. The address then increments modulo 2^instMem_addr_width and the remaining count decrements. The last byte goes to CHK, or to FINISH without CHECKSUM_EN.
- A SYNC_BYTE value inside the header or payload is ordinary data; there is no resync mid-frame.
- CHK: CHK must equal the 8-bit sum (mod 256) of ADDR_H, ADDR_L, LEN_H, LEN_L and all payload bytes.
  - Match: go to FINISH.
  - Mismatch: set `err`, clear `busy`, return to IDLE, no `done`.
- FINISH: one cycle. `done`=1, `busy` clears on exit, `in_ready`=0, then IDLE.
- Writes already issued before a checksum failure are not undone.

## Timing
- Reset values while `rst` is high: state IDLE, `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0.
- Reset asserted mid-frame aborts the frame immediately. No further writes occur.
- `in_ready` is 1 in every state except FINISH and reset, so up to one byte is accepted per cycle.
- `wr_en`, `wr_addr` and `wr_data` are registered. The write appears in the cycle after payload byte acceptance, lasts one cycle, and back-to-back writes are allowed.
- `busy` rises in the cycle after SYNC acceptance.
- `done` is high in the cycle after the final byte (CHK or last payload/LEN_L) is accepted. That cycle coincides with the last `wr_en` when no CHK follows.
- `err` rises in the cycle after a bad CHK is accepted. It holds until the next SYNC acceptance or reset.
- Stalls (`in_valid`=0) are allowed anywhere. State, address and count hold.

## Configuration
- `INST_LOADER_CHECKSUM_EN` defined:
  - CHK byte is expected and checked.
  - `err` is functional.
- `INST_LOADER_CHECKSUM_EN` undefined:
  - No CHK byte; the frame ends after the last payload byte (or LEN_L when length is 0).
  - `err` is tied to 0.
  - The running sum logic is removed.

## Test plan
- Basic load, CHECKSUM_EN, stream A5 00 10 00 04 00 00 00 13 27 with `in_valid` held high:
  - Required: writes (0x0010,00), (0x0011,00), (0x0012,00), (0x0013,13) on consecutive cycles.
  - Required: `done` pulses once; `err`=0.
- Bad checksum, same frame with CHK=28:
  - Required: 4 writes, no `done`, `err`=1, `busy`=0.
  - Then a following good frame: `err` clears at its SYNC.
- Wrap-around, header A5 1F FE 00 04, payload 11 22 33 44:
  - Required: write addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Leading garbage, length 0: stream 00 FF A5 00 00 00 00 00:
  - Required: no writes, `done` pulse, `busy` high only between SYNC and FINISH.
- Stall and reset abort:
  - Random `in_valid` gaps give the same writes as the basic load.
  - `rst` asserted after the 2nd payload byte: exactly 2 writes, all outputs 0, state IDLE.
- CHECKSUM_EN undefined, stream A5 00 10 00 04 00 00 00 13:
  - Required: `done` coincides with the 4th write.
  - A following byte 27 is discarded in IDLE.
